// File: rtl/mem_access_ctrl_pkg.sv
// LC-3b shared types for the memory-stage access sequencer: word/opcode types,
// opcode constants, sequencer state and lane mask, plus opcode classifiers.
package mem_access_ctrl_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;
    typedef logic [1:0]  lc3b_mem_mask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2
    } lc3b_mem_state;

    localparam lc3b_opcode op_br   = 4'b0000;
    localparam lc3b_opcode op_add  = 4'b0001;
    localparam lc3b_opcode op_ldb  = 4'b0010;
    localparam lc3b_opcode op_stb  = 4'b0011;
    localparam lc3b_opcode op_jsr  = 4'b0100;
    localparam lc3b_opcode op_and  = 4'b0101;
    localparam lc3b_opcode op_ldr  = 4'b0110;
    localparam lc3b_opcode op_str  = 4'b0111;
    localparam lc3b_opcode op_rti  = 4'b1000;
    localparam lc3b_opcode op_not  = 4'b1001;
    localparam lc3b_opcode op_ldi  = 4'b1010;
    localparam lc3b_opcode op_sti  = 4'b1011;
    localparam lc3b_opcode op_jmp  = 4'b1100;
    localparam lc3b_opcode op_shf  = 4'b1101;
    localparam lc3b_opcode op_lea  = 4'b1110;
    localparam lc3b_opcode op_trap = 4'b1111;

    function automatic logic is_mem_op(input lc3b_opcode op);
        case (op)
            op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti, op_trap: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

    function automatic logic is_store(input lc3b_opcode op);
        return (op == op_str) || (op == op_stb) || (op == op_sti);
    endfunction

    function automatic logic is_byte_op(input lc3b_opcode op);
        return (op == op_ldb) || (op == op_stb);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Memory-stage bundle: pipeline stage inputs, data-memory port and stall/load result.
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic         valid_in;
    lc3b_opcode   opcode;
    lc3b_word     address_in;
    lc3b_word     wdata_in;
    logic         dmem_resp;
    lc3b_word     dmem_rdata;
    logic         dmem_read;
    logic         dmem_write;
    lc3b_word     dmem_address;
    lc3b_word     dmem_wdata;
    lc3b_mem_mask dmem_byte_enable;
    lc3b_word     mem_rdata;
    logic         mem_stall;

    // Environment side: pipeline latch and memory model
    modport master (
        output valid_in, opcode, address_in, wdata_in, dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  mem_rdata, mem_stall
    );

    // Sequencer side
    modport slave (
        input  valid_in, opcode, address_in, wdata_in, dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output mem_rdata, mem_stall
    );

endinterface

// File: rtl/mem_access_ctrl_byte_align.sv
// Byte-lane steering: store data replication and lane mask, LDB byte select
// with zero extension. Purely combinational.
module mem_byte_align
    import mem_access_ctrl_pkg::*;
(
    input  lc3b_opcode   i_st_op,
    input  logic         i_st_addr0,
    input  lc3b_word     i_wdata,
    input  lc3b_opcode   i_ld_op,
    input  logic         i_ld_addr0,
    input  lc3b_word     i_rdata,
    output lc3b_word     o_wdata,
    output lc3b_mem_mask o_mask,
    output lc3b_word     o_rdata
);

    // Store data and lane selection
    always_comb begin
        o_wdata = i_wdata;
        o_mask  = 2'b00;
        case (i_st_op)
            op_stb: begin
                o_wdata = {i_wdata[7:0], i_wdata[7:0]};
                o_mask  = i_st_addr0 ? 2'b10 : 2'b01;
            end
            op_str, op_sti: begin
                o_wdata = i_wdata;
                o_mask  = 2'b11;
            end
            default: begin
                o_wdata = i_wdata;
                o_mask  = 2'b00;
            end
        endcase
    end

    // Load result: byte loads pick the addressed lane and zero-extend
    always_comb begin
        o_rdata = i_rdata;
        case (i_ld_op)
            op_ldb: begin
                if (i_ld_addr0) begin
                    o_rdata = {8'h00, i_rdata[15:8]};
                end else begin
                    o_rdata = {8'h00, i_rdata[7:0]};
                end
            end
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b memory-stage access sequencer: one data access for LDR/LDB/STR/STB/TRAP,
// pointer read then data access for LDI/STI, stalling the pipe until completion.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    mem_access_ctrl_if.slave   bus
);

    lc3b_mem_state r_state;
    lc3b_word      r_ptr_q;
    lc3b_opcode    r_op;
    logic          r_read;
    logic          r_write;
    lc3b_word      r_address;
    lc3b_word      r_wdata;
    lc3b_mem_mask  r_byte_enable;

    logic          w_mem_op;
    logic          w_done;
    lc3b_word      w_wdata_aligned;
    lc3b_mem_mask  w_mask;
    lc3b_word      w_rdata_aligned;

    assign w_mem_op = bus.valid_in & is_mem_op(bus.opcode);
    assign w_done   = (r_state == DATA) & bus.dmem_resp;

    // Store steering uses the live stage latch; load select uses the captured op
    // and the registered address, whose bit 0 is kept for byte ops.
    mem_byte_align u_align (
        .i_st_op    (bus.opcode),
        .i_st_addr0 (bus.address_in[0]),
        .i_wdata    (bus.wdata_in),
        .i_ld_op    (r_op),
        .i_ld_addr0 (r_address[0]),
        .i_rdata    (bus.dmem_rdata),
        .o_wdata    (w_wdata_aligned),
        .o_mask     (w_mask),
        .o_rdata    (w_rdata_aligned)
    );

    // Sequencer FSM with registered request outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_ptr_q       <= 16'h0000;
            r_op          <= 4'b0000;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_address     <= 16'h0000;
            r_wdata       <= 16'h0000;
            r_byte_enable <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_op    <= bus.opcode;
                        r_wdata <= w_wdata_aligned;
                        if (is_indirect(bus.opcode)) begin
                            r_state       <= PTR;
                            r_read        <= 1'b1;
                            r_write       <= 1'b0;
                            r_address     <= {bus.address_in[15:1], 1'b0};
                            r_byte_enable <= 2'b00;
                        end else begin
                            r_state       <= DATA;
                            r_read        <= ~is_store(bus.opcode);
                            r_write       <= is_store(bus.opcode);
                            r_address     <= is_byte_op(bus.opcode) ? bus.address_in
                                                                    : {bus.address_in[15:1], 1'b0};
                            r_byte_enable <= w_mask;
                        end
                    end else begin
                        r_state       <= IDLE;
                        r_read        <= 1'b0;
                        r_write       <= 1'b0;
                        r_byte_enable <= 2'b00;
                    end
                end
                PTR: begin
                    if (bus.dmem_resp) begin
                        r_ptr_q   <= bus.dmem_rdata;
                        r_state   <= DATA;
                        r_address <= {bus.dmem_rdata[15:1], 1'b0};
                        if (r_op == op_sti) begin
                            r_read        <= 1'b0;
                            r_write       <= 1'b1;
                            r_byte_enable <= 2'b11;
                        end else begin
                            r_read        <= 1'b1;
                            r_write       <= 1'b0;
                            r_byte_enable <= 2'b00;
                        end
                    end else begin
                        r_state <= PTR;
                    end
                end
                DATA: begin
                    if (bus.dmem_resp) begin
                        r_state       <= IDLE;
                        r_read        <= 1'b0;
                        r_write       <= 1'b0;
                        r_byte_enable <= 2'b00;
                    end else begin
                        r_state <= DATA;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_read        <= 1'b0;
                    r_write       <= 1'b0;
                    r_byte_enable <= 2'b00;
                end
            endcase
        end
    end

    assign bus.dmem_read        = r_read;
    assign bus.dmem_write       = r_write;
    assign bus.dmem_address     = r_address;
    assign bus.dmem_wdata       = r_wdata;
    assign bus.dmem_byte_enable = r_byte_enable;
    assign bus.mem_rdata        = w_rdata_aligned;
    // Gated by reset so an abandoned access never leaves the pipe frozen
    assign bus.mem_stall        = reset_n & w_mem_op & ~w_done;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: inputs change 1 ns after the
// rising edge, outputs are checked on the falling edge.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    mem_access_ctrl_if bus_if();

    mem_access_ctrl u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input lc3b_opcode op, input lc3b_word a,
                         input lc3b_word wd, input logic rsp, input lc3b_word rd);
        bus_if.valid_in   = v;
        bus_if.opcode     = op;
        bus_if.address_in = a;
        bus_if.wdata_in   = wd;
        bus_if.dmem_resp  = rsp;
        bus_if.dmem_rdata = rd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({bus_if.dmem_read, bus_if.dmem_write} !== 2'b00) begin
            n_err++; $display("FAIL reset_req: got %b expected 00", {bus_if.dmem_read, bus_if.dmem_write}); end
        n_cmp++; if (bus_if.dmem_address !== 16'h0000) begin
            n_err++; $display("FAIL reset_addr: got %h expected 0000", bus_if.dmem_address); end
        n_cmp++; if (bus_if.dmem_byte_enable !== 2'b00) begin
            n_err++; $display("FAIL reset_be: got %b expected 00", bus_if.dmem_byte_enable); end
        n_cmp++; if (bus_if.mem_stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: got %b expected 0", bus_if.mem_stall); end
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_ldr_wait();
        int stall_cycles;
        stall_cycles = 0;
        drive(1'b1, op_ldr, 16'h3005, 16'h0000, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus_if.dmem_resp  = 1'b1;
                bus_if.dmem_rdata = 16'h1357;
            end
            @(negedge clk);
            if (bus_if.mem_stall === 1'b1) stall_cycles++;
            if (i > 0) begin
                n_cmp++; if (bus_if.dmem_read !== 1'b1 || bus_if.dmem_address !== 16'h3004) begin
                    n_err++; $display("FAIL ldr_req c%0d: got rd=%b addr=%h expected rd=1 addr=3004",
                                      i, bus_if.dmem_read, bus_if.dmem_address); end
            end
            next_cycle();
        end
        n_cmp++; if (stall_cycles !== 3) begin
            n_err++; $display("FAIL ldr_stall_cycles: got %0d expected 3", stall_cycles); end
        bus_if.dmem_resp = 1'b0;
        bus_if.valid_in  = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_read !== 1'b0) begin
            n_err++; $display("FAIL ldr_idle_read: got %b expected 0", bus_if.dmem_read); end
        next_cycle();
    endtask

    // The completion-cycle checks of mem_rdata are in test_ldr_data/test_ldi
    task automatic test_ldr_data();
        drive(1'b1, op_ldr, 16'h3005, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
        bus_if.dmem_resp  = 1'b1;
        bus_if.dmem_rdata = 16'h1357;
        @(negedge clk);
        n_cmp++; if (bus_if.mem_rdata !== 16'h1357 || bus_if.mem_stall !== 1'b0) begin
            n_err++; $display("FAIL ldr_rdata: got %h stall=%b expected 1357 stall=0",
                              bus_if.mem_rdata, bus_if.mem_stall); end
        next_cycle();
        drive(1'b0, op_add, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
    endtask

    task automatic test_ldi();
        drive(1'b1, op_ldi, 16'h4000, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        n_cmp++; if (bus_if.mem_stall !== 1'b1 || bus_if.dmem_read !== 1'b0) begin
            n_err++; $display("FAIL ldi_c0: got stall=%b rd=%b expected stall=1 rd=0",
                              bus_if.mem_stall, bus_if.dmem_read); end
        next_cycle();
        bus_if.dmem_resp  = 1'b1;
        bus_if.dmem_rdata = 16'h5002;
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_read !== 1'b1 || bus_if.dmem_address !== 16'h4000 || bus_if.mem_stall !== 1'b1) begin
            n_err++; $display("FAIL ldi_ptr: got rd=%b addr=%h stall=%b expected rd=1 addr=4000 stall=1",
                              bus_if.dmem_read, bus_if.dmem_address, bus_if.mem_stall); end
        next_cycle();
        bus_if.dmem_rdata = 16'hBEEF;
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_read !== 1'b1 || bus_if.dmem_address !== 16'h5002) begin
            n_err++; $display("FAIL ldi_data_req: got rd=%b addr=%h expected rd=1 addr=5002",
                              bus_if.dmem_read, bus_if.dmem_address); end
        n_cmp++; if (bus_if.mem_rdata !== 16'hBEEF || bus_if.mem_stall !== 1'b0) begin
            n_err++; $display("FAIL ldi_rdata: got %h stall=%b expected beef stall=0",
                              bus_if.mem_rdata, bus_if.mem_stall); end
        next_cycle();
        drive(1'b0, op_add, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
    endtask

    task automatic test_stb(input lc3b_word a, input lc3b_mem_mask exp_be);
        drive(1'b1, op_stb, a, 16'h12AB, 1'b0, 16'h0000);
        next_cycle();
        bus_if.dmem_resp = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_write !== 1'b1 || bus_if.dmem_read !== 1'b0 || bus_if.dmem_wdata !== 16'hABAB) begin
            n_err++; $display("FAIL stb_req %h: got wr=%b rd=%b wdata=%h expected wr=1 rd=0 wdata=abab",
                              a, bus_if.dmem_write, bus_if.dmem_read, bus_if.dmem_wdata); end
        n_cmp++; if (bus_if.dmem_byte_enable !== exp_be || bus_if.dmem_address !== a) begin
            n_err++; $display("FAIL stb_lane %h: got be=%b addr=%h expected be=%b addr=%h",
                              a, bus_if.dmem_byte_enable, bus_if.dmem_address, exp_be, a); end
        next_cycle();
        drive(1'b0, op_add, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_write !== 1'b0) begin
            n_err++; $display("FAIL stb_idle_write: got %b expected 0", bus_if.dmem_write); end
        next_cycle();
    endtask

    task automatic test_ldb(input lc3b_word a, input lc3b_word exp);
        drive(1'b1, op_ldb, a, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
        bus_if.dmem_resp  = 1'b1;
        bus_if.dmem_rdata = 16'hA55A;
        @(negedge clk);
        n_cmp++; if (bus_if.mem_rdata !== exp || bus_if.dmem_address !== a) begin
            n_err++; $display("FAIL ldb %h: got rdata=%h addr=%h expected rdata=%h addr=%h",
                              a, bus_if.mem_rdata, bus_if.dmem_address, exp, a); end
        next_cycle();
        drive(1'b0, op_add, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
    endtask

    task automatic test_sti();
        drive(1'b1, op_sti, 16'h7000, 16'hCAFE, 1'b0, 16'h0000);
        next_cycle();
        bus_if.valid_in   = 1'b0;
        bus_if.dmem_resp  = 1'b1;
        bus_if.dmem_rdata = 16'h7100;
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_read !== 1'b1 || bus_if.dmem_write !== 1'b0 || bus_if.dmem_address !== 16'h7000) begin
            n_err++; $display("FAIL sti_ptr: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=7000",
                              bus_if.dmem_read, bus_if.dmem_write, bus_if.dmem_address); end
        next_cycle();
        bus_if.dmem_rdata = 16'h0000;
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_write !== 1'b1 || bus_if.dmem_read !== 1'b0 || bus_if.dmem_address !== 16'h7100) begin
            n_err++; $display("FAIL sti_data_req: got wr=%b rd=%b addr=%h expected wr=1 rd=0 addr=7100",
                              bus_if.dmem_write, bus_if.dmem_read, bus_if.dmem_address); end
        n_cmp++; if (bus_if.dmem_wdata !== 16'hCAFE || bus_if.dmem_byte_enable !== 2'b11) begin
            n_err++; $display("FAIL sti_data: got wdata=%h be=%b expected cafe 11",
                              bus_if.dmem_wdata, bus_if.dmem_byte_enable); end
        next_cycle();
        bus_if.dmem_resp = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus_if.dmem_read, bus_if.dmem_write} !== 2'b00) begin
            n_err++; $display("FAIL sti_done: got %b expected 00", {bus_if.dmem_read, bus_if.dmem_write}); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, op_ldr, 16'h1000, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
        bus_if.dmem_resp = 1'b1;
        next_cycle();
        drive(1'b1, op_trap, 16'h0021, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_read !== 1'b0 || bus_if.mem_stall !== 1'b1) begin
            n_err++; $display("FAIL b2b_dead: got rd=%b stall=%b expected rd=0 stall=1",
                              bus_if.dmem_read, bus_if.mem_stall); end
        next_cycle();
        bus_if.dmem_resp  = 1'b1;
        bus_if.dmem_rdata = 16'h0400;
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_read !== 1'b1 || bus_if.dmem_address !== 16'h0020 || bus_if.mem_rdata !== 16'h0400) begin
            n_err++; $display("FAIL b2b_trap: got rd=%b addr=%h rdata=%h expected rd=1 addr=0020 rdata=0400",
                              bus_if.dmem_read, bus_if.dmem_address, bus_if.mem_rdata); end
        next_cycle();
        drive(1'b0, op_add, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
    endtask

    task automatic test_passthrough();
        drive(1'b0, op_ldr, 16'h2222, 16'h0000, 1'b1, 16'h0000);
        @(negedge clk);
        n_cmp++; if (bus_if.mem_stall !== 1'b0) begin
            n_err++; $display("FAIL pass_invalid_stall: got %b expected 0", bus_if.mem_stall); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({bus_if.dmem_read, bus_if.dmem_write} !== 2'b00) begin
            n_err++; $display("FAIL pass_idle_resp: got %b expected 00", {bus_if.dmem_read, bus_if.dmem_write}); end
        drive(1'b1, op_lea, 16'h2222, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
        @(negedge clk);
        n_cmp++; if (bus_if.mem_stall !== 1'b0 || bus_if.dmem_read !== 1'b0) begin
            n_err++; $display("FAIL pass_lea: got stall=%b rd=%b expected 0 0", bus_if.mem_stall, bus_if.dmem_read); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, op_ldi, 16'h4000, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
        bus_if.dmem_resp  = 1'b1;
        bus_if.dmem_rdata = 16'h5002;
        next_cycle();
        bus_if.dmem_resp = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_if.dmem_read !== 1'b1 || bus_if.dmem_address !== 16'h5002) begin
            n_err++; $display("FAIL rst_pre: got rd=%b addr=%h expected rd=1 addr=5002",
                              bus_if.dmem_read, bus_if.dmem_address); end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({bus_if.dmem_read, bus_if.dmem_write} !== 2'b00 || bus_if.mem_stall !== 1'b0) begin
            n_err++; $display("FAIL rst_async: got req=%b stall=%b expected 00 0",
                              {bus_if.dmem_read, bus_if.dmem_write}, bus_if.mem_stall); end
        next_cycle();
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, op_add, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        #1;
        n_cmp++; if (bus_if.mem_stall !== 1'b0) begin
            n_err++; $display("FAIL rst_add_stall: got %b expected 0", bus_if.mem_stall); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({bus_if.dmem_read, bus_if.dmem_write} !== 2'b00 || bus_if.mem_stall !== 1'b0) begin
            n_err++; $display("FAIL rst_add_idle: got req=%b stall=%b expected 00 0",
                              {bus_if.dmem_read, bus_if.dmem_write}, bus_if.mem_stall); end
        next_cycle();
    endtask

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        n_cmp   = 0;
        n_err   = 0;
        drive(1'b0, op_add, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        test_reset();
        test_ldr_wait();
        test_ldr_data();
        test_ldi();
        test_stb(16'h6001, 2'b10);
        test_stb(16'h6000, 2'b01);
        test_ldb(16'h2003, 16'h00A5);
        test_ldb(16'h2002, 16'h005A);
        test_sti();
        test_back_to_back();
        test_passthrough();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
